jk_excitation_driver: RTL and testbench

JK_EXCITATION_DRIVER -- requirements
Module: jk_excitation_driver

---
 rtl/jk_excitation_driver.sv | 186 ++++++++++++++++++
 tb/tb_jk_excitation_driver.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
// Drives a bank of JK flip-flops towards a requested value. A request
// produces a single-cycle excitation pulse on J/K, waits for the bank to
// settle, and then compares the fed-back Q against the latched target.
// A mismatch triggers another pulse, computed from the current Q, until the
// retry allowance is used up. Completion is reported with a one-cycle Done
// pulse, and Error is raised alongside Done when the target was never reached.

module jk_excitation_driver #(
    parameter int WIDTH     = 4,
    parameter int SETTLE    = 1,
    parameter int MAX_RETRY = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Target,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             Busy,
    output logic             Done,
    output logic             Error
);

    // The settle counter and retry counter are narrow and fixed in width.
    // SETTLE tops out at 15 and MAX_RETRY tops out at 7, so 4 and 3 bits cover
    // the full legal ranges.
    localparam logic [3:0] SettleLast = 4'(SETTLE - 1);
    localparam logic [2:0] RetryLimit = 3'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] target_q, target_d;
    logic             mode_q,   mode_d;
    logic [2:0]       retry_q,  retry_d;
    logic [3:0]       settle_q, settle_d;
    logic [WIDTH-1:0] j_q,      j_d;
    logic [WIDTH-1:0] k_q,      k_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             error_q,  error_d;

    // Excitation source selection and the resulting J/K values.
    logic [WIDTH-1:0] exTarget;
    logic             exMode;
    logic [WIDTH-1:0] exJ;
    logic [WIDTH-1:0] exK;

    // In IDLE the pulse is built from the incoming request, because it has
    // not been latched yet. Retries always use the latched request.
    always_comb begin
        exTarget = target_q;
        exMode   = mode_q;
        if (state_q == S_IDLE) begin
            exTarget = Target;
            exMode   = Mode;
        end
    end

    // Per-bit excitation table. Bits that already match get J=K=0. A bit
    // rising gets J (plus K in toggle mode). A bit falling gets K (plus J in
    // toggle mode).
    always_comb begin
        exJ = (~Q_fb & exTarget) | (Q_fb & ~exTarget & {WIDTH{exMode}});
        exK = (Q_fb & ~exTarget) | (~Q_fb & exTarget & {WIDTH{exMode}});
    end

    // Next-state and next-output logic. J/K and the Done/Error pulses default
    // to zero, so they are only non-zero in the single cycle that follows the
    // branch that sets them.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        mode_d   = mode_q;
        retry_d  = retry_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        j_d      = '0;
        k_d      = '0;
        done_d   = 1'b0;
        error_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (Start) begin
                    target_d = Target;
                    mode_d   = Mode;
                    retry_d  = '0;
                    j_d      = exJ;
                    k_d      = exK;
                    busy_d   = 1'b1;
                    state_d  = S_DRIVE;
                end
            end

            S_DRIVE: begin
                settle_d = '0;
                state_d  = S_SETTLE;
            end

            S_SETTLE: begin
                if (settle_q == SettleLast) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            S_CHECK: begin
                if (Q_fb == target_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (retry_q < RetryLimit) begin
                    retry_d = retry_q + 3'd1;
                    j_d     = exJ;
                    k_d     = exK;
                    state_d = S_DRIVE;
                end else begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register. Reset returns to IDLE at once, without waiting for
    // a clock edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request, counters, and the registered outputs. All of them are
    // cleared asynchronously, so the bank stops being excited at once.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            target_q <= '0;
            mode_q   <= 1'b0;
            retry_q  <= '0;
            settle_q <= '0;
            j_q      <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            target_q <= target_d;
            mode_q   <= mode_d;
            retry_q  <= retry_d;
            settle_q <= settle_d;
            j_q      <= j_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign J     = j_q;
    assign K     = k_q;
    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Error = error_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb_jk_excitation_driver
// Surrounds the driver with a 4-bit JK bank model. Each issued request pushes
// its expected outcome into a queue. A monitor pops one entry per Done pulse
// and compares it with what the DUT actually did.

module tb_jk_excitation_driver;

    localparam int W  = 4;
    localparam int ST = 1;
    localparam int MR = 2;

    logic         Clk    = 1'b0;
    logic         Rst_n  = 1'b0;
    logic         Start  = 1'b0;
    logic [W-1:0] Target = '0;
    logic         Mode   = 1'b0;
    logic [W-1:0] Q_fb;
    logic [W-1:0] J;
    logic [W-1:0] K;
    logic         Busy;
    logic         Done;
    logic         Error;

    // Bank controls. The bench can load a value into the bank, or hold it
    // stuck at a fixed value so the driver's retries never take effect.
    logic [W-1:0] bankQ    = '0;
    logic         loadBank = 1'b0;
    logic [W-1:0] loadVal  = '0;
    logic         stuck    = 1'b0;
    logic [W-1:0] stuckVal = '0;

    int compared   = 0;
    int mismatched = 0;

    // Expected outcome of one operation
    typedef struct {
        logic         err;
        int           busy;
        int           pulses;
        logic [W-1:0] fJ;
        logic [W-1:0] fK;
        logic [W-1:0] lJ;
        logic [W-1:0] lK;
        logic [W-1:0] fq;
    } exp_t;

    exp_t expQ[$];

    // Monitor tracking for the operation currently in flight
    int           busyCnt  = 0;
    int           pulseCnt = 0;
    logic [W-1:0] mfJ      = '0;
    logic [W-1:0] mfK      = '0;
    logic [W-1:0] mlJ      = '0;
    logic [W-1:0] mlK      = '0;
    logic         quiet    = 1'b1;
    logic         prevDone = 1'b0;

    jk_excitation_driver #(
        .WIDTH    (W),
        .SETTLE   (ST),
        .MAX_RETRY(MR)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Start (Start),
        .Target(Target),
        .Mode  (Mode),
        .Q_fb  (Q_fb),
        .J     (J),
        .K     (K),
        .Busy  (Busy),
        .Done  (Done),
        .Error (Error)
    );

    // Free-running clock with a 10-unit period
    always #5 Clk = ~Clk;

    // JK bank model: each bit holds, sets, resets or toggles according to the
    // J/K pair it sees at the rising edge.
    always @(posedge Clk) begin
        if (loadBank) begin
            bankQ <= loadVal;
        end else if (stuck) begin
            bankQ <= stuckVal;
        end else begin
            for (int b = 0; b < W; b++) begin
                case ({J[b], K[b]})
                    2'b10:   bankQ[b] <= 1'b1;
                    2'b01:   bankQ[b] <= 1'b0;
                    2'b11:   bankQ[b] <= ~bankQ[b];
                    default: ;
                endcase
            end
        end
    end

    assign Q_fb = bankQ;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference outcome: repeat attempts of "excite, let the bank react,
    // compare" until the target is reached or the attempt allowance runs out.
    function automatic exp_t modelOp(input logic [W-1:0] q0, input logic [W-1:0] tgt,
                                     input logic md, input logic stk,
                                     input logic [W-1:0] stkVal);
        exp_t         e;
        logic [W-1:0] q;
        logic [W-1:0] j;
        logic [W-1:0] k;
        int           attempts;
        q        = q0;
        attempts = 0;
        e.err    = 1'b1;
        e.pulses = 0;
        e.fJ     = '0;
        e.fK     = '0;
        e.lJ     = '0;
        e.lK     = '0;
        for (int a = 0; a <= MR; a++) begin
            j = '0;
            k = '0;
            for (int b = 0; b < W; b++) begin
                if (!q[b] && tgt[b]) begin
                    j[b] = 1'b1;
                    k[b] = md;
                end else if (q[b] && !tgt[b]) begin
                    j[b] = md;
                    k[b] = 1'b1;
                end
            end
            if (a == 0) begin
                e.fJ = j;
                e.fK = k;
            end
            e.lJ = j;
            e.lK = k;
            if ((j | k) != '0) e.pulses++;
            attempts++;
            if (stk) begin
                q = stkVal;
            end else begin
                for (int b = 0; b < W; b++) begin
                    q[b] = (j[b] & ~q[b]) | (~k[b] & q[b]);
                end
            end
            if (q == tgt) begin
                e.err = 1'b0;
                break;
            end
        end
        e.busy = attempts * (2 + ST);
        e.fq   = q;
        return e;
    endfunction

    // Issue one request in the first cycle the DUT is idle, and push its
    // expected outcome. When "immediate" is set, the caller is already
    // standing on the negedge at which the request is driven.
    task automatic applyStimulus(input logic [W-1:0] tgt, input logic md, input bit immediate = 1'b0);
        int n;
        n = 0;
        if (!immediate) begin
            @(negedge Clk);
            while (Busy && n < 100) begin
                @(negedge Clk);
                n++;
            end
            if (Busy) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL idleWait: got busy after %0d cycles, expected idle", n);
            end
        end
        Target = tgt;
        Mode   = md;
        Start  = 1'b1;
        expQ.push_back(modelOp(Q_fb, tgt, md, stuck, stuckVal));
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    task automatic setBank(input logic [W-1:0] v);
        int n;
        n = 0;
        @(negedge Clk);
        while (Busy && n < 100) begin
            @(negedge Clk);
            n++;
        end
        loadVal  = v;
        loadBank = 1'b1;
        @(posedge Clk);
        #1 loadBank = 1'b0;
    endtask

    // Wait for Done, sampling #1 after each rising edge, and return how many
    // edges that took.
    task automatic waitDone(output int edges);
        edges = 0;
        do begin
            @(posedge Clk);
            #1;
            edges++;
        end while (!Done && edges < 100);
        if (!Done) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL doneWait: got no Done after %0d edges, expected Done", edges);
        end
    endtask

    // Monitor: follows each operation on the falling edge and checks the
    // popped expectation when Done appears.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Rst_n) begin
                busyCnt  = 0;
                pulseCnt = 0;
                quiet    = 1'b1;
                prevDone = 1'b0;
                continue;
            end
            if (prevDone) begin
                checkOutput("donePulseWidth", 32'(Done), 32'd0);
                checkOutput("errorPulseWidth", 32'(Error), 32'd0);
            end
            if (Busy) begin
                if (busyCnt % (2 + ST) == 0) begin
                    if (busyCnt == 0) begin
                        mfJ = J;
                        mfK = K;
                    end
                    mlJ = J;
                    mlK = K;
                    if ((J | K) != '0) pulseCnt++;
                end else if ((J | K) != '0) begin
                    quiet = 1'b0;
                end
                busyCnt++;
            end
            if (Done) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedDone: got Done, expected no operation pending");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("error", 32'(Error), 32'(e.err));
                    checkOutput("busyCycles", busyCnt, e.busy);
                    checkOutput("drivePulses", pulseCnt, e.pulses);
                    checkOutput("firstJ", 32'(mfJ), 32'(e.fJ));
                    checkOutput("firstK", 32'(mfK), 32'(e.fK));
                    checkOutput("lastJ", 32'(mlJ), 32'(e.lJ));
                    checkOutput("lastK", 32'(mlK), 32'(e.lK));
                    checkOutput("jkQuietOutsideDrive", 32'(quiet), 32'd1);
                    checkOutput("finalQ", 32'(Q_fb), 32'(e.fq));
                    checkOutput("busyAtDone", 32'(Busy), 32'd0);
                    checkOutput("jkAtDone", 32'({J, K}), 32'd0);
                end
                busyCnt  = 0;
                pulseCnt = 0;
                quiet    = 1'b1;
            end
            prevDone = Done;
        end
    end

    // Directed scenarios first, then randomized back-to-back operations.
    initial begin
        int n;

        #2;
        checkOutput("resetJ", 32'(J), 32'd0);
        checkOutput("resetK", 32'(K), 32'd0);
        checkOutput("resetBusy", 32'(Busy), 32'd0);
        checkOutput("resetDone", 32'(Done), 32'd0);
        checkOutput("resetError", 32'(Error), 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Minimal excitation 0101 -> 0011
        setBank(4'b0101);
        applyStimulus(4'b0011, 1'b0);
        checkOutput("minimalJ", 32'(J), 32'b0010);
        checkOutput("minimalK", 32'(K), 32'b0100);
        waitDone(n);
        checkOutput("minimalLatency", n, 3);
        checkOutput("minimalQ", 32'(Q_fb), 32'b0011);
        checkOutput("minimalError", 32'(Error), 32'd0);

        // Toggle-preferred excitation 0101 -> 0011
        setBank(4'b0101);
        applyStimulus(4'b0011, 1'b1);
        checkOutput("toggleJ", 32'(J), 32'b0110);
        checkOutput("toggleK", 32'(K), 32'b0110);
        waitDone(n);
        checkOutput("toggleQ", 32'(Q_fb), 32'b0011);

        // Bank stuck at 0000: three attempts, then Error with Done
        stuckVal = 4'b0000;
        stuck    = 1'b1;
        @(posedge Clk);
        #1;
        applyStimulus(4'b1000, 1'b0);
        waitDone(n);
        checkOutput("stuckLatency", n, 9);
        checkOutput("stuckError", 32'(Error), 32'd1);
        stuck = 1'b0;

        // Start while busy is ignored, and Start during Done is accepted
        applyStimulus(4'b0110, 1'b0);
        @(negedge Clk);
        Target = 4'b1111;
        Mode   = 1'b1;
        Start  = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        Target = 4'b0000;
        waitDone(n);
        checkOutput("ignoredStartQ", 32'(Q_fb), 32'b0110);
        applyStimulus(4'b1001, 1'b0);
        checkOutput("backToBackBusy", 32'(Busy), 32'd1);
        waitDone(n);

        // Target already equal to Q
        setBank(4'b1010);
        applyStimulus(4'b1010, 1'($urandom));
        checkOutput("equalJK", 32'({J, K}), 32'd0);
        waitDone(n);
        checkOutput("equalLatency", n, 3);
        checkOutput("equalError", 32'(Error), 32'd0);

        // Reset during the DRIVE cycle
        setBank(4'b0110);
        applyStimulus(4'b1001, 1'b0);
        checkOutput("preResetJ", 32'(J), 32'b1001);
        #1 Rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("midResetJ", 32'(J), 32'd0);
        checkOutput("midResetK", 32'(K), 32'd0);
        checkOutput("midResetBusy", 32'(Busy), 32'd0);
        checkOutput("midResetDone", 32'(Done), 32'd0);
        @(posedge Clk);
        #1;
        checkOutput("bankHeldInReset", 32'(Q_fb), 32'b0110);
        @(negedge Clk);
        Rst_n = 1'b1;
        applyStimulus(4'b0101, 1'b1, 1'b1);
        checkOutput("startAfterReset", 32'(Busy), 32'd1);
        waitDone(n);

        // Randomized operations, issued back to back
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) setBank(4'($urandom));
            applyStimulus(4'($urandom), 1'($urandom));
        end

        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(negedge Clk);
            n++;
        end
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending operations, expected 0", expQ.size());
        end
        repeat (3) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
